// File: rtl/shift_pkg.sv
// Shared types for the multi-cycle shift sequencer: op encodings, FSM states, data width.
package shift_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_step.sv
// One fixed-distance shift stage (STEP or 1 bit), purely combinational, no backpressure.
// Sign fill for op 11 exists only when SHIFT_SRA_EN is defined; otherwise op 11 shifts as SRL.
module shift_step
  import shift_pkg::*;
#(
  parameter int STEP = 4
) (
  input  logic [XLEN-1:0] i_acc,
  input  logic [1:0]      i_op,
  input  logic            i_coarse,
  output logic [XLEN-1:0] o_acc
);

  logic w_right;

  // Op 10 is not a right shift, so it falls through to the left-shift path.
  assign w_right = (i_op == SH_SRL) || (i_op == SH_SRA);

`ifdef SHIFT_SRA_EN
  logic w_arith;
  assign w_arith = (i_op == SH_SRA);

  always_comb begin
    o_acc = i_acc;
    if (!w_right) begin
      o_acc = i_coarse ? (i_acc << STEP) : (i_acc << 1);
    end else if (w_arith) begin
      o_acc = i_coarse ? XLEN'($signed(i_acc) >>> STEP) : XLEN'($signed(i_acc) >>> 1);
    end else begin
      o_acc = i_coarse ? (i_acc >> STEP) : (i_acc >> 1);
    end
  end
`else
  always_comb begin
    o_acc = i_acc;
    if (!w_right) begin
      o_acc = i_coarse ? (i_acc << STEP) : (i_acc << 1);
    end else begin
      o_acc = i_coarse ? (i_acc >> STEP) : (i_acc >> 1);
    end
  end
`endif

endmodule

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shifter: STEP bits/cycle then 1 bit/cycle; response after shamt/STEP+shamt%STEP+1 cycles.
// One request in flight; result held in DONE until resp_ready_i; SHIFT_SRA_EN enables sign fill.
module shift_seq_ctrl
  import shift_pkg::*;
#(
  parameter int STEP = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] data_i,
  input  logic [4:0]      shamt_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);

  localparam logic [4:0] STEP_W = 5'(STEP);

  state_e          r_state;
  state_e          w_state_nxt;
  logic [XLEN-1:0] r_acc;
  logic [4:0]      r_rem;
  logic [1:0]      r_op;

  logic            w_accept;
  logic            w_coarse;
  logic [4:0]      w_rem_nxt;
  logic [XLEN-1:0] w_step_acc;

  assign w_accept  = req_valid_i && (r_state == IDLE);
  assign w_coarse  = (r_rem >= STEP_W);
  // The 1-bit step is only taken with r_rem >= 1 in SHIFT, so this never wraps.
  assign w_rem_nxt = r_rem - (w_coarse ? STEP_W : 5'd1);

  shift_step #(
    .STEP(STEP)
  ) u_step (
    .i_acc   (r_acc),
    .i_op    (r_op),
    .i_coarse(w_coarse),
    .o_acc   (w_step_acc)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = (shamt_i != 5'd0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        if (w_rem_nxt == 5'd0) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (resp_ready_i) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o  = (r_state == IDLE);
    resp_valid_o = (r_state == DONE);
    busy_o       = (r_state != IDLE);
    result_o     = (r_state == DONE) ? r_acc : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_acc <= '0;
      r_rem <= '0;
      r_op  <= '0;
    end else if (w_accept) begin
      r_acc <= data_i;
      r_rem <= shamt_i;
      r_op  <= op_i;
    end else if (r_state == SHIFT) begin
      r_acc <= w_step_acc;
      r_rem <= w_rem_nxt;
    end
  end

endmodule
